// File: rtl/histogram_engine.sv
`default_nettype none
// ============================================================================
// Module      : histogram_engine
// Description : Bins samples by their top BIN_W bits into saturating or
//               wrapping counters and dumps the result over a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module histogram_engine #(
    parameter int DATA_W    = 8,
    parameter int BIN_W     = 4,
    parameter int CNT_W     = 8,
    parameter int SATURATE  = 1,
    parameter int CLR_ON_RD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIN_W-1:0]  out_bin,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last,
    output logic              busy,
    output logic              sat,
    output logic [7:0]        drop_cnt
);

    localparam int              NUM_BINS  = 1 << BIN_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DUMP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_bins [NUM_BINS];
    logic [BIN_W-1:0] r_out_bin;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_sat;
    logic [7:0]       r_drop_cnt;

    logic [BIN_W-1:0] w_idx;
    logic             w_clear;
    logic             w_accum_hit;
    logic             w_drop;
    logic             w_handshake;
    logic             w_is_last;
    logic             w_unused;

    assign w_idx       = smp_data[DATA_W-1 -: BIN_W];
    // Start is honoured everywhere except DUMP, and a restart beats a same-cycle sample.
    assign w_clear     = start && (r_state != S_DUMP);
    assign w_accum_hit = (r_state == S_ACCUM) && smp_valid && !start;
    assign w_drop      = smp_valid && (r_state != S_ACCUM);
    assign w_handshake = r_out_valid && out_ready;
    assign w_is_last   = (r_out_bin == {BIN_W{1'b1}});
    assign w_unused    = ^smp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_bin   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ACCUM;
                        r_busy  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (!start && stop) begin
                        r_state     <= S_DUMP;
                        r_out_bin   <= '0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DUMP: begin
                    if (w_handshake) begin
                        if (w_is_last) begin
                            r_state     <= S_IDLE;
                            r_out_bin   <= '0;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_out_bin <= r_out_bin + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_bin   <= '0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BINS; i++) begin
                if (w_clear) begin
                    r_bins[i] <= '0;
                end else if (w_accum_hit && (w_idx == BIN_W'(i))) begin
                    // Natural CNT_W overflow of the adder gives the wrap behaviour.
                    if ((r_bins[i] != c_CNT_MAX) || (SATURATE == 0))
                        r_bins[i] <= r_bins[i] + 1'b1;
                end else if ((CLR_ON_RD != 0) && w_handshake && (r_out_bin == BIN_W'(i))) begin
                    r_bins[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_clear)
                r_sat <= 1'b0;
            else if (w_accum_hit && (r_bins[w_idx] == c_CNT_MAX))
                r_sat <= 1'b1;

            if (w_clear)
                r_drop_cnt <= '0;
            else if (w_drop && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_bin   = r_out_bin;
    assign out_count = r_bins[r_out_bin];
    assign out_last  = r_out_valid && w_is_last;
    assign busy      = r_busy;
    assign sat       = r_sat;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_histogram_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_histogram_engine
// Description : Randomised bench for histogram_engine; two instances
//               (saturate/keep and wrap/clear-on-read) against a bin-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_histogram_engine;

    localparam int NB   = 16;
    localparam int CMAX = 255;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, smp_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] smp_data = '0;

    logic       out_valid_a, out_last_a, busy_a, sat_a;
    logic [3:0] out_bin_a;
    logic [7:0] out_count_a, drop_a;
    logic       out_valid_b, out_last_b, busy_b, sat_b;
    logic [3:0] out_bin_b;
    logic [7:0] out_count_b, drop_b;

    histogram_engine #(.DATA_W(8), .BIN_W(4), .CNT_W(8), .SATURATE(1), .CLR_ON_RD(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .smp_valid(smp_valid), .smp_data(smp_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_bin(out_bin_a),
        .out_count(out_count_a), .out_last(out_last_a), .busy(busy_a),
        .sat(sat_a), .drop_cnt(drop_a)
    );

    histogram_engine #(.DATA_W(8), .BIN_W(4), .CNT_W(8), .SATURATE(0), .CLR_ON_RD(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .smp_valid(smp_valid), .smp_data(smp_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_bin(out_bin_b),
        .out_count(out_count_b), .out_last(out_last_b), .busy(busy_b),
        .sat(sat_b), .drop_cnt(drop_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = idle, 1 = accumulating, 2 = dumping
    int m_mode;
    int m_a [NB];
    int m_b [NB];
    bit m_sat_a, m_sat_b;
    int m_drop;
    int m_bin;
    int got_a [NB];
    int got_b [NB];

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            m_a[i] = 0;
            m_b[i] = 0;
        end
        m_sat_a = 0;
        m_sat_b = 0;
        m_drop  = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_mode = 0;
        m_bin  = 0;
    endtask

    // Apply the rules to the current inputs, then advance one clock.
    task automatic tick();
        int idx;
        idx = int'(smp_data[7:4]);
        case (m_mode)
            0: begin
                if (start) begin
                    model_clear();
                    m_mode = 1;
                end else if (smp_valid && m_drop < 255) begin
                    m_drop++;
                end
            end
            1: begin
                if (start) begin
                    model_clear();
                end else begin
                    if (smp_valid) begin
                        if (m_a[idx] == CMAX) m_sat_a = 1; else m_a[idx]++;
                        if (m_b[idx] == CMAX) begin m_sat_b = 1; m_b[idx] = 0; end
                        else m_b[idx]++;
                    end
                    if (stop) begin
                        m_mode = 2;
                        m_bin  = 0;
                    end
                end
            end
            default: begin
                if (smp_valid && m_drop < 255) m_drop++;
                if (out_ready) begin
                    m_b[m_bin] = 0;
                    if (m_bin == NB - 1) begin
                        m_mode = 0;
                        m_bin  = 0;
                    end else begin
                        m_bin++;
                    end
                end
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic sample(input logic [7:0] d);
        smp_valid = 1'b1; smp_data = d; tick(); smp_valid = 1'b0;
    endtask

    task automatic run_dump(input bit rand_ready, input string tag);
        int   beats;
        int   cyc;
        bit   stalled;
        logic [3:0] p_bin;
        logic [7:0] p_cnt;
        logic       p_last;
        beats = 0; cyc = 0; stalled = 0;
        p_bin = '0; p_cnt = '0; p_last = 1'b0;
        for (int i = 0; i < NB; i++) begin got_a[i] = -1; got_b[i] = -1; end
        while (m_mode == 2 && cyc < 400) begin
            out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            n_tests++;
            if (out_valid_a !== 1'b1 || out_valid_b !== 1'b1) begin
                n_fail++;
                $display("FAIL %s valid: got a=%b b=%b want 1", tag, out_valid_a, out_valid_b);
            end
            n_tests++;
            if (out_bin_a !== 4'(m_bin) || out_bin_b !== 4'(m_bin)) begin
                n_fail++;
                $display("FAIL %s out_bin: got a=%0d b=%0d want %0d", tag, out_bin_a, out_bin_b, m_bin);
            end
            n_tests++;
            if (out_count_a !== 8'(m_a[m_bin]) || out_count_b !== 8'(m_b[m_bin])) begin
                n_fail++;
                $display("FAIL %s count bin%0d: got a=%0d b=%0d want a=%0d b=%0d",
                         tag, m_bin, out_count_a, out_count_b, m_a[m_bin], m_b[m_bin]);
            end
            n_tests++;
            if (out_last_a !== (m_bin == NB - 1) || out_last_b !== (m_bin == NB - 1)) begin
                n_fail++;
                $display("FAIL %s out_last bin%0d: got a=%b b=%b want %b",
                         tag, m_bin, out_last_a, out_last_b, (m_bin == NB - 1));
            end
            if (stalled) begin
                n_tests++;
                if ({out_bin_a, out_count_a, out_last_a} !== {p_bin, p_cnt, p_last}) begin
                    n_fail++;
                    $display("FAIL %s stall_stable: got %h/%0d/%b want %h/%0d/%b",
                             tag, out_bin_a, out_count_a, out_last_a, p_bin, p_cnt, p_last);
                end
            end
            if (out_ready) begin
                got_a[m_bin] = int'(out_count_a);
                got_b[m_bin] = int'(out_count_b);
                beats++;
            end
            stalled = !out_ready;
            p_bin = out_bin_a; p_cnt = out_count_a; p_last = out_last_a;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        n_tests++;
        if (beats !== NB) begin
            n_fail++;
            $display("FAIL %s beats: got %0d want %0d", tag, beats, NB);
        end
        n_tests++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || out_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end_idle: got busy=%b%b valid=%b want 0", tag, busy_a, busy_b, out_valid_a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid_a, busy_a, sat_a, out_last_a, out_valid_b, busy_b, sat_b, out_last_b} !== 8'h00
            || drop_a !== 8'd0 || drop_b !== 8'd0 || out_bin_a !== 4'd0 || out_bin_b !== 4'd0) begin
            n_fail++;
            $display("FAIL reset: got v=%b b=%b s=%b d=%0d bin=%0d want all 0",
                     out_valid_a, busy_a, sat_a, drop_a, out_bin_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] pat [6];
        pat = '{8'h00, 8'h0F, 8'h10, 8'hFF, 8'hFF, 8'hFF};
        pulse_start();
        foreach (pat[i]) sample(pat[i]);
        pulse_stop();
        run_dump(1'b0, "basic");
        n_tests++;
        if (got_a[0] != 2 || got_a[1] != 1 || got_a[15] != 3) begin
            n_fail++;
            $display("FAIL basic_bins: got %0d/%0d/%0d want 2/1/3", got_a[0], got_a[1], got_a[15]);
        end
        for (int i = 2; i < 15; i++) begin
            if (got_a[i] != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL basic_zero bin%0d: got %0d want 0", i, got_a[i]);
            end
        end
    endtask

    task automatic test_overflow();
        pulse_start();
        repeat (300) sample(8'h55);
        n_tests++;
        if (sat_a !== 1'b1 || sat_b !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sat: got a=%b b=%b want 1", sat_a, sat_b);
        end
        pulse_stop();
        run_dump(1'b1, "overflow");
        n_tests++;
        if (got_a[5] != 255 || got_b[5] != 44) begin
            n_fail++;
            $display("FAIL overflow_bin5: got a=%0d b=%0d want 255/44", got_a[5], got_b[5]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            pulse_start();
            n_tests++;
            if (sat_a !== 1'b0 || sat_b !== 1'b0 || drop_a !== 8'd0) begin
                n_fail++;
                $display("FAIL random_start_clear: got sat=%b%b drop=%0d want 0", sat_a, sat_b, drop_a);
            end
            repeat (150) begin
                smp_valid = ($urandom_range(0, 3) != 0);
                smp_data  = 8'($urandom);
                tick();
            end
            smp_valid = 1'b1;
            smp_data  = 8'($urandom);
            stop      = 1'b1;
            tick();
            stop = 1'b0; smp_valid = 1'b0;
            run_dump(1'b1, "random");
            n_tests++;
            if (sat_a !== m_sat_a || sat_b !== m_sat_b) begin
                n_fail++;
                $display("FAIL random_sat: got a=%b b=%b want a=%b b=%b", sat_a, sat_b, m_sat_a, m_sat_b);
            end
        end
    endtask

    task automatic test_edges();
        pulse_start();
        sample(8'h30);
        sample(8'h30);
        start = 1'b1; smp_valid = 1'b1; smp_data = 8'h30;
        tick();
        smp_valid = 1'b0;
        stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_tests++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL start_over_stop: got valid=%b busy=%b want 0/1", out_valid_a, busy_a);
        end
        stop = 1'b1; smp_valid = 1'b1; smp_data = 8'h7A;
        tick();
        stop = 1'b0; smp_valid = 1'b0;
        run_dump(1'b0, "edges");
        n_tests++;
        if (got_a[3] != 0 || got_a[7] != 1) begin
            n_fail++;
            $display("FAIL edges_bins: got bin3=%0d bin7=%0d want 0/1", got_a[3], got_a[7]);
        end
        pulse_stop();
        n_tests++;
        if (busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_in_idle: got busy=%b valid=%b want 0", busy_a, out_valid_a);
        end
    endtask

    task automatic test_drops();
        pulse_start();
        repeat (20) sample(8'($urandom));
        pulse_stop();
        out_ready = 1'b0;
        repeat (3) sample(8'($urandom));
        pulse_start();
        run_dump(1'b1, "drops_dump");
        repeat (5) sample(8'($urandom));
        n_tests++;
        if (drop_a !== 8'd8 || drop_b !== 8'd8) begin
            n_fail++;
            $display("FAIL drop_cnt: got a=%0d b=%0d want 8", drop_a, drop_b);
        end
        pulse_start();
        pulse_stop();
        run_dump(1'b0, "drops_second");
        for (int i = 0; i < NB; i++) begin
            if (got_a[i] != 0 || got_b[i] != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL second_dump bin%0d: got a=%0d b=%0d want 0", i, got_a[i], got_b[i]);
            end
        end
        repeat (260) sample(8'($urandom));
        n_tests++;
        if (drop_a !== 8'd255 || drop_b !== 8'd255) begin
            n_fail++;
            $display("FAIL drop_saturate: got a=%0d b=%0d want 255", drop_a, drop_b);
        end
    endtask

    task automatic test_reset_mid_dump();
        pulse_start();
        repeat (40) sample(8'($urandom));
        pulse_stop();
        out_ready = 1'b1;
        repeat (7) tick();
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || out_bin_a !== 4'd0 || sat_a !== 1'b0
            || out_valid_b !== 1'b0 || busy_b !== 1'b0 || drop_a !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b busy=%b bin=%0d sat=%b want 0",
                     out_valid_a, busy_a, out_bin_a, sat_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        pulse_stop();
        run_dump(1'b1, "after_reset");
        for (int i = 0; i < NB; i++) begin
            if (got_a[i] != 0 || got_b[i] != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL after_reset bin%0d: got a=%0d b=%0d want 0", i, got_a[i], got_b[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_random();
        test_edges();
        test_drops();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
